// File: rtl/burst_gen_pkg.sv
// Shared state encoding, default widths and sizing helper for the burst generator.
// Replaces the old udar_defs.vh include; encodings are unchanged.
package burst_gen_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        BURST = 2'd2,
        BLANK = 2'd3
    } state_t;

    // Width for a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/burst_gen_if.sv
// Control/drive bundle between the burst generator and its controller.
interface burst_gen_if import burst_gen_pkg::*; #(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             tick_in;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] burst_len;
    logic             tx_p;
    logic             tx_n;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output tick_in, start, abort, burst_len,
        input  tx_p, tx_n, busy, done, err
    );

    modport slave (
        input  tick_in, start, abort, burst_len,
        output tx_p, tx_n, busy, done, err
    );
endinterface

// File: rtl/burst_gen_tick_edge.sv
// Edge detector for the same-domain divided tick; one register, sync reset.
module tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic tick_rise,
    output logic tick_fall
);
    logic tick_q;

    always_ff @(posedge clk) begin
        if (rst) tick_q <= 1'b0;
        else     tick_q <= tick_in;
    end

    assign tick_rise = tick_in & ~tick_q;
    assign tick_fall = ~tick_in & tick_q;
endmodule

// File: rtl/burst_gen.sv
// Ultrasonic transmit burst generator: len_q drive periods, blanking window,
// done/err reporting, with a tick-stall watchdog.
module burst_gen import burst_gen_pkg::*; #(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned BLANK_TICKS = 16,
    parameter int unsigned ARM_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    burst_gen_if.slave bus
);
    localparam int unsigned BCNT_W = cnt_width(BLANK_TICKS);
    localparam int unsigned WD_W   = cnt_width(ARM_TIMEOUT);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_TICKS - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(ARM_TIMEOUT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] len_q, len_n;
    logic [CNT_W-1:0] pcnt, pcnt_n;
    logic [BCNT_W-1:0] bcnt, bcnt_n;
    logic [WD_W-1:0]  wd, wd_n;
    logic             tx_p_q, tx_p_n, tx_n_q, tx_n_n;
    logic             busy_q, done_q, done_n, err_q, err_n;
    logic             tick_rise, tick_fall;

    tick_edge u_tick_edge (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (bus.tick_in),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            len_q  <= '0;
            pcnt   <= '0;
            bcnt   <= '0;
            wd     <= '0;
            tx_p_q <= 1'b0;
            tx_n_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            len_q  <= len_n;
            pcnt   <= pcnt_n;
            bcnt   <= bcnt_n;
            wd     <= wd_n;
            tx_p_q <= tx_p_n;
            tx_n_q <= tx_n_n;
            busy_q <= (state_n != IDLE);
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len_q;
        pcnt_n  = pcnt;
        bcnt_n  = bcnt;
        wd_n    = wd;
        tx_p_n  = tx_p_q;
        tx_n_n  = tx_n_q;
        done_n  = 1'b0;
        err_n   = 1'b0;

        if (bus.abort) begin
            state_n = IDLE;
            tx_p_n  = 1'b0;
            tx_n_n  = 1'b0;
        end else if (state != IDLE && wd == WD_LAST) begin
            state_n = IDLE;
            err_n   = 1'b1;
            tx_p_n  = 1'b0;
            tx_n_n  = 1'b0;
        end else begin
            // Watchdog counts every active cycle and restarts on either tick edge.
            if (state != IDLE)
                wd_n = (tick_rise | tick_fall) ? '0 : wd + 1'b1;

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.burst_len != '0) begin
                            state_n = ARM;
                            len_n   = bus.burst_len;
                            wd_n    = '0;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (tick_rise) begin
                        state_n = BURST;
                        pcnt_n  = '0;
                        tx_p_n  = 1'b1;
                        tx_n_n  = 1'b0;
                    end
                end
                BURST: begin
                    if (tick_rise) begin
                        if (pcnt == len_q - CNT_W'(1)) begin
                            state_n = BLANK;
                            bcnt_n  = '0;
                            tx_p_n  = 1'b0;
                            tx_n_n  = 1'b0;
                        end else begin
                            pcnt_n = pcnt + 1'b1;
                            tx_p_n = 1'b1;
                            tx_n_n = 1'b0;
                        end
                    end else if (tick_fall) begin
                        tx_p_n = 1'b0;
                        tx_n_n = 1'b1;
                    end
                end
                BLANK: begin
                    tx_p_n = 1'b0;
                    tx_n_n = 1'b0;
                    if (tick_rise) begin
                        if (bcnt == BCNT_LAST) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            bcnt_n = bcnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.tx_p = tx_p_q;
    assign bus.tx_n = tx_n_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_burst_gen.sv
// Self-checking bench for burst_gen: per-cycle comparison against a rule-level
// model (counts tick rises since arming) plus directed literal checks.
module tb_burst_gen;
    import burst_gen_pkg::*;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned BLANK_TICKS = 16;
    localparam int unsigned ARM_TIMEOUT = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    burst_gen_if #(.CNT_W(CNT_W)) bus ();

    burst_gen #(
        .CNT_W       (CNT_W),
        .BLANK_TICKS (BLANK_TICKS),
        .ARM_TIMEOUT (ARM_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Tick source: hi_len cycles high, lo_len cycles low, or held low when stopped.
    bit          tick_run = 1'b0;
    int unsigned hi_len   = 4;
    int unsigned lo_len   = 4;
    int unsigned tph      = 0;

    always @(negedge clk) begin
        if (!tick_run) begin
            bus.tick_in = 1'b0;
            tph = 0;
        end else begin
            bus.tick_in = (tph < hi_len);
            tph = (tph + 1 >= hi_len + lo_len) ? 0 : tph + 1;
        end
    end

    // Reference model: a burst is "active" from the accepted start; drive follows
    // the tick level while 1..len rises have been seen, done on rise len+1+BLANK.
    bit          m_act   = 1'b0;
    bit          m_prev  = 1'b0;
    int unsigned m_len   = 0;
    int unsigned m_rises = 0;
    int unsigned m_quiet = 0;
    bit e_txp = 1'b0, e_txn = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

    always @(posedge clk) begin
        bit tk, rise, edg, drive;
        tk   = bus.tick_in;
        rise = tk & ~m_prev;
        edg  = tk ^ m_prev;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            m_act = 1'b0; e_txp = 1'b0; e_txn = 1'b0; tk = 1'b0;
        end else if (bus.abort) begin
            m_act = 1'b0; e_txp = 1'b0; e_txn = 1'b0;
        end else if (m_act) begin
            if (m_quiet == ARM_TIMEOUT - 1) begin
                m_act = 1'b0; e_err = 1'b1; e_txp = 1'b0; e_txn = 1'b0;
            end else begin
                m_quiet = edg ? 0 : m_quiet + 1;
                if (rise) m_rises++;
                if (m_rises == m_len + 1 + BLANK_TICKS) begin
                    m_act = 1'b0; e_done = 1'b1;
                end
                drive = (m_rises >= 1) && (m_rises <= m_len);
                e_txp = drive && tk;
                e_txn = drive && !tk;
            end
        end else if (bus.start) begin
            if (bus.burst_len != '0) begin
                m_act = 1'b1; m_len = bus.burst_len; m_rises = 0; m_quiet = 0;
            end else begin
                e_done = 1'b1;
            end
        end
        m_prev = tk;
        e_busy = m_act;
    end

    always @(posedge clk) begin
        #5;
        check("tx_p",    int'(bus.tx_p), int'(e_txp));
        check("tx_n",    int'(bus.tx_n), int'(e_txn));
        check("busy",    int'(bus.busy), int'(e_busy));
        check("done",    int'(bus.done), int'(e_done));
        check("err",     int'(bus.err),  int'(e_err));
        check("tx_excl", int'(bus.tx_p & bus.tx_n), 0);
        check("done_err_excl", int'(bus.done & bus.err), 0);
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int unsigned len);
        bus.burst_len = CNT_W'(len);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Observe one burst until done/err; optionally re-issue start (len 7) at spam_at.
    task automatic run_count(input int unsigned maxc, input int unsigned spam_at,
                             output int unsigned np, output int unsigned nn,
                             output int unsigned pulses, output int unsigned gap,
                             output int unsigned mnp, output int unsigned busy_end,
                             output int unsigned fin_done);
        int unsigned idx = 0, last_tx = 0;
        logic pp = 1'b0;
        np = 0; nn = 0; pulses = 0; gap = 0; mnp = 0; busy_end = 1; fin_done = 0;
        while (idx < maxc) begin
            if (spam_at != 0 && idx == spam_at) begin
                bus.burst_len = CNT_W'(7);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            idx++;
            if (bus.tx_p) np++;
            if (bus.tx_n) nn++;
            if (e_txp) mnp++;
            if (bus.tx_p && !pp) pulses++;
            pp = bus.tx_p;
            if (bus.tx_p || bus.tx_n) last_tx = idx;
            if (bus.done || bus.err) begin
                fin_done = bus.done;
                busy_end = bus.busy;
                gap = idx - last_tx - 1;
                break;
            end
        end
        bus.start = 1'b0;
        check("burst_finished", int'(bus.done | bus.err), 1);
    endtask

    initial begin
        int unsigned np, nn, pulses, gap, mnp, busy_end, fin_done, n, cnt_de;
        logic pp;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.burst_len = '0;
        tick_run = 1'b1;

        // Reset
        rst = 1'b1;
        cyc(5);
        check("rst_tx_p", int'(bus.tx_p), 0);
        check("rst_tx_n", int'(bus.tx_n), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err",  int'(bus.err),  0);
        rst = 1'b0;
        cyc(3);

        // Three-period burst with full blanking
        pulse_start(3);
        check("t1_busy_next", int'(bus.busy), 1);
        run_count(600, 0, np, nn, pulses, gap, mnp, busy_end, fin_done);
        check("t1_tx_p_cycles", int'(np), 12);
        check("t1_tx_n_cycles", int'(nn), 12);
        check("t1_model_tx_p",  int'(mnp), 12);
        check("t1_periods",     int'(pulses), 3);
        check("t1_blank_gap",   int'(gap), 128);
        check("t1_done",        int'(fin_done), 1);
        check("t1_busy_at_done", int'(busy_end), 0);
        cyc(1);
        check("t1_done_single", int'(bus.done), 0);
        cyc(5);

        // Zero-length request
        pulse_start(0);
        check("t2_done", int'(bus.done), 1);
        check("t2_model_done", int'(e_done), 1);
        check("t2_busy", int'(bus.busy), 0);
        check("t2_tx_p", int'(bus.tx_p), 0);
        cyc(1);
        check("t2_done_clear", int'(bus.done), 0);
        cyc(5);

        // Abort during the second period
        pulse_start(10);
        n = 0; pulses = 0; pp = 1'b0;
        while (pulses < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.tx_p && !pp) pulses++;
            pp = bus.tx_p;
        end
        check("t3_reached_p2", int'(pulses), 2);
        cyc(2);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t3_tx_p", int'(bus.tx_p), 0);
        check("t3_tx_n", int'(bus.tx_n), 0);
        check("t3_busy", int'(bus.busy), 0);
        cnt_de = 0;
        repeat (200) begin
            @(negedge clk);
            cnt_de += int'(bus.done) + int'(bus.err);
        end
        check("t3_no_done_err", int'(cnt_de), 0);

        // Stalled tick -> watchdog
        tick_run = 1'b0;
        cyc(3);
        pulse_start(4);
        check("t4_busy", int'(bus.busy), 1);
        n = 0; np = 0;
        while (!bus.err && n < 1100) begin
            @(negedge clk);
            n++;
            np += int'(bus.tx_p | bus.tx_n);
        end
        check("t4_err_latency", int'(n), 1024);
        check("t4_no_drive", int'(np), 0);
        check("t4_busy_after", int'(bus.busy), 0);
        cyc(1);
        check("t4_err_single", int'(bus.err), 0);
        tick_run = 1'b1;
        cyc(10);

        // start while busy is ignored
        pulse_start(3);
        run_count(600, 30, np, nn, pulses, gap, mnp, busy_end, fin_done);
        check("t5_periods", int'(pulses), 3);
        check("t5_tx_p_cycles", int'(np), 12);
        check("t5_done", int'(fin_done), 1);
        cyc(3);
        bus.burst_len = CNT_W'(5);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("t5_sa_busy", int'(bus.busy), 0);
        check("t5_sa_done", int'(bus.done), 0);
        cyc(5);

        // Reset during blanking, then a single period
        pulse_start(2);
        cyc(50);
        check("t6_in_blank_busy", int'(bus.busy), 1);
        check("t6_in_blank_quiet", int'(bus.tx_p | bus.tx_n), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_busy", int'(bus.busy), 0);
        check("t6_rst_done", int'(bus.done), 0);
        check("t6_rst_tx", int'(bus.tx_p | bus.tx_n), 0);
        cyc(2);
        pulse_start(1);
        run_count(400, 0, np, nn, pulses, gap, mnp, busy_end, fin_done);
        check("t6_tx_p_cycles", int'(np), 4);
        check("t6_tx_n_cycles", int'(nn), 4);
        check("t6_periods", int'(pulses), 1);
        check("t6_done", int'(fin_done), 1);
        cyc(5);

        // Randomized traffic checked by the per-cycle model
        for (int i = 0; i < 40; i++) begin
            int unsigned wait_c;
            hi_len = $urandom_range(1, 5);
            lo_len = $urandom_range(1, 5);
            tick_run = ($urandom_range(0, 9) != 0);
            bus.burst_len = CNT_W'($urandom_range(0, 5));
            bus.start = 1'b1;
            bus.abort = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            wait_c = tick_run ? $urandom_range(50, 300) : 1100;
            for (int c = 0; c < int'(wait_c); c++) begin
                bus.start = ($urandom_range(0, 29) == 0);
                bus.burst_len = CNT_W'($urandom_range(0, 6));
                bus.abort = ($urandom_range(0, 149) == 0);
                rst = ($urandom_range(0, 399) == 0);
                @(negedge clk);
            end
            bus.start = 1'b0;
            bus.abort = 1'b0;
            rst = 1'b0;
        end
        tick_run = 1'b1;
        cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
